// File: rtl/mem_stage_if.sv
// Data-memory and IO bus channels driven by the memory-access stage.
// The master modport is the pipeline side; the slave modport is the memory/IO side.
interface mem_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [13:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        io_req_o;
    logic        io_we_o;
    logic [15:0] io_addr_o;
    logic [31:0] io_wdata_o;
    logic [31:0] io_rdata_i;
    logic        io_ack_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_rdata_i, dmem_ack_i,
        output io_req_o, io_we_o, io_addr_o, io_wdata_o,
        input  io_rdata_i, io_ack_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_rdata_i, dmem_ack_i,
        input  io_req_o, io_we_o, io_addr_o, io_wdata_o,
        output io_rdata_i, io_ack_i
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory or IO transactions, stalls
// upstream while they are outstanding, and loads the MEM/WB register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    input  logic        reg_write_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        mem_or_io_to_reg_i,
    input  logic        io_read_i,
    input  logic        io_write_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    mem_stage_if.master bus,
    output logic        wb_valid_o,
    output logic        wb_reg_write_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_fault_o
);
    typedef enum logic [1:0] {IDLE, MEM_WAIT, IO_WAIT, RESP} state_t;

    state_t      state_r, next_state_s;
    logic [7:0]  cnt_r;
    logic [31:0] buf_r;
    logic        fault_r;
    logic        dmem_req_r, dmem_we_r, io_req_r, io_we_r;
    logic [13:0] dmem_addr_r;
    logic [15:0] io_addr_r;
    logic [31:0] dmem_wdata_r, io_wdata_r;
    logic        access_s, is_io_s;
    logic        issue_io_s, issue_mem_s, mem_done_s, io_ack_done_s, io_to_s;
    logic        wb_load_in_s, wb_load_resp_s;

    assign access_s = in_valid_i & (mem_read_i | mem_write_i | io_read_i | io_write_i);
    assign is_io_s  = io_read_i | io_write_i;

    // Gated by rst_n so every output reads 0 while reset is held.
    assign stall_o = rst_n & (((state_r == IDLE) & access_s) |
                              (state_r == MEM_WAIT) | (state_r == IO_WAIT));

    assign bus.dmem_req_o   = dmem_req_r;
    assign bus.dmem_we_o    = dmem_we_r;
    assign bus.dmem_addr_o  = dmem_addr_r;
    assign bus.dmem_wdata_o = dmem_wdata_r;
    assign bus.io_req_o     = io_req_r;
    assign bus.io_we_o      = io_we_r;
    assign bus.io_addr_o    = io_addr_r;
    assign bus.io_wdata_o   = io_wdata_r;

    // Next-state decode and per-cycle transaction events.
    always_comb begin
        next_state_s   = state_r;
        issue_io_s     = 1'b0;
        issue_mem_s    = 1'b0;
        mem_done_s     = 1'b0;
        io_ack_done_s  = 1'b0;
        io_to_s        = 1'b0;
        wb_load_in_s   = 1'b0;
        wb_load_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s && is_io_s) begin
                    next_state_s = IO_WAIT;
                    issue_io_s   = 1'b1;
                end else if (access_s) begin
                    next_state_s = MEM_WAIT;
                    issue_mem_s  = 1'b1;
                end else begin
                    wb_load_in_s = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ack_i) begin
                    mem_done_s   = 1'b1;
                    next_state_s = RESP;
                end else begin
                    next_state_s = MEM_WAIT;
                end
            end
            IO_WAIT: begin
                // An ack on the final counted cycle still beats the timeout.
                if (bus.io_ack_i) begin
                    io_ack_done_s = 1'b1;
                    next_state_s  = RESP;
                end else if (cnt_r == 8'(TIMEOUT - 1)) begin
                    io_to_s       = 1'b1;
                    next_state_s  = RESP;
                end else begin
                    next_state_s  = IO_WAIT;
                end
            end
            RESP: begin
                wb_load_resp_s = 1'b1;
                next_state_s   = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Bus request registers; address/we/wdata are latched only at issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 14'd0;
            dmem_wdata_r <= 32'd0;
            io_req_r     <= 1'b0;
            io_we_r      <= 1'b0;
            io_addr_r    <= 16'd0;
            io_wdata_r   <= 32'd0;
        end else begin
            if (issue_mem_s) begin
                dmem_req_r   <= 1'b1;
                dmem_we_r    <= mem_write_i;
                dmem_addr_r  <= alu_result_i[15:2];
                dmem_wdata_r <= store_data_i;
            end else if (mem_done_s) begin
                dmem_req_r   <= 1'b0;
            end else begin
                dmem_req_r   <= dmem_req_r;
            end
            if (issue_io_s) begin
                io_req_r   <= 1'b1;
                io_we_r    <= io_write_i;
                io_addr_r  <= alu_result_i[15:0];
                io_wdata_r <= store_data_i;
            end else if (io_ack_done_s || io_to_s) begin
                io_req_r   <= 1'b0;
            end else begin
                io_req_r   <= io_req_r;
            end
        end
    end

    // IO wait counter, response buffer and fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 8'd0;
            buf_r   <= 32'd0;
            fault_r <= 1'b0;
        end else begin
            if (issue_io_s) begin
                cnt_r <= 8'd0;
            end else if (state_r == IO_WAIT) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (mem_done_s) begin
                buf_r   <= bus.dmem_rdata_i;
                fault_r <= 1'b0;
            end else if (io_ack_done_s) begin
                buf_r   <= bus.io_rdata_i;
                fault_r <= 1'b0;
            end else if (io_to_s) begin
                buf_r   <= 32'd0;
                fault_r <= 1'b1;
            end else begin
                buf_r   <= buf_r;
                fault_r <= fault_r;
            end
        end
    end

    // MEM/WB register; a bubble is inserted while the stage is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= 5'd0;
            wb_data_o      <= 32'd0;
            wb_fault_o     <= 1'b0;
        end else if (wb_load_in_s || wb_load_resp_s) begin
            wb_valid_o     <= in_valid_i;
            wb_reg_write_o <= in_valid_i & reg_write_i & (rd_i != 5'd0);
            wb_rd_o        <= rd_i;
            wb_data_o      <= mem_or_io_to_reg_i ? buf_r : alu_result_i;
            wb_fault_o     <= wb_load_resp_s ? fault_r : 1'b0;
        end else begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= 5'd0;
            wb_data_o      <= 32'd0;
            wb_fault_o     <= 1'b0;
        end
    end
endmodule
